// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: hex segment table,
// blank pattern and decimal-point bit position (all active-low).
package seg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DP_BIT = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Index = hex nibble; bit 7 (dp) is off in every entry.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low 7-segment decode with blanking and
// decimal point; the dp is driven even when the digit is blanked.
module seg_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  input  logic             i_dp,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_TABLE[i_nibble];
    if (i_blank) o_seg_c = SEG_BLANK;
    o_seg_c[DP_BIT] = ~i_dp;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner with double-buffered display data that swaps
// only at frame boundaries. Optional macro SEG_BRIGHTNESS_EN adds PWM dimming.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 100000
)(
  input  logic                clk,
  input  logic                reset,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [3:0]          bright,
`endif
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                wr_en,
  input  logic                blank_lz,
  output logic                upd_ack,
  output logic [DIGITS-1:0]   an,
  output logic [SEG_W-1:0]    seg
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PCNT_W = $clog2(TICK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [PCNT_W-1:0] r_pcnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_disp_data;
  logic [DIGITS-1:0] r_disp_dp;
  logic [DATA_W-1:0] r_pend_data;
  logic [DIGITS-1:0] r_pend_dp;
  logic              r_pend_valid;

  logic              w_tick;
  logic              w_frame;
  logic [NIB_W-1:0]  w_nib;
  logic              w_dp;
  logic [DIGITS-1:0] w_lead_zero;
  logic              w_zero_run;
  logic              w_blank;
  logic [DIGITS-1:0] w_an_sel;
  logic              w_pwm_on;
  logic [SEG_W-1:0]  w_seg_c;

  assign w_tick  = (r_pcnt == PCNT_LAST);
  assign w_frame = w_tick && (r_idx == IDX_LAST);

  // Select the current digit and find which digits sit in the leading-zero run.
  always_comb begin
    w_nib       = '0;
    w_dp        = 1'b0;
    w_an_sel    = '1;
    w_lead_zero = '0;
    w_zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run     = w_zero_run && (r_disp_data[4*i +: 4] == 4'h0);
      w_lead_zero[i] = w_zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp_data[4*i +: 4];
        w_dp        = r_disp_dp[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  // Digit 0 stays lit even when every nibble is zero.
  always_comb begin
    w_blank = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_blank = blank_lz && w_lead_zero[i];
    end
  end

`ifdef SEG_BRIGHTNESS_EN
  logic [3:0] r_pwm_cnt;
  assign w_pwm_on = (r_pwm_cnt <= bright);

  always_ff @(posedge clk) begin
    if (!reset) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end
`else
  assign w_pwm_on = 1'b1;
`endif

  seg_decode u_decode (
    .i_nibble (w_nib),
    .i_dp     (w_dp),
    .i_blank  (w_blank),
    .o_seg_c  (w_seg_c)
  );

  // A write landing on the boundary cycle stays pending for the next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      upd_ack      <= 1'b0;
      an           <= '1;
      seg          <= SEG_BLANK;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PCNT_W'(1);
      if (w_tick) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

      upd_ack <= w_frame && r_pend_valid;
      if (w_frame && r_pend_valid) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
      end

      if (wr_en) begin
        r_pend_data  <= data;
        r_pend_dp    <= dp_in;
        r_pend_valid <= 1'b1;
      end else if (w_frame) begin
        r_pend_valid <= 1'b0;
      end

      an  <= ((r_pcnt == '0) || !w_pwm_on) ? '1 : w_an_sel;
      seg <= w_seg_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux (DIGITS=4, TICK_DIV=4).
// Define SEG_BRIGHTNESS_EN to also exercise the PWM dimming path.
module tb_seg_scan_mux;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        wr_en;
  logic        blank_lz;
  logic        upd_ack;
  logic [3:0]  an;
  logic [7:0]  seg;
`ifdef SEG_BRIGHTNESS_EN
  logic [3:0]  bright;
`endif

  int n_checks;
  int n_pass;
  int n_fail;
  int cyc;

  seg_scan_mux #(.DIGITS(4), .TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef SEG_BRIGHTNESS_EN
    .bright   (bright),
`endif
    .data     (data),
    .dp_in    (dp_in),
    .wr_en    (wr_en),
    .blank_lz (blank_lz),
    .upd_ack  (upd_ack),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Advance to cycle n, counting upd_ack pulses seen along the way.
  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    while (cyc < n) begin
      tick();
      if (upd_ack) pulses++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp);
    wr_en = 1'b1;
    data  = d;
    dp_in = dp;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [7:0] an_of(input int d);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    return {4'h0, a};
  endfunction

  logic [7:0] exp_s2 [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
  logic [7:0] exp_s3 [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
  logic [7:0] exp_z  [4] = '{8'hC0, 8'hFF, 8'h7F, 8'hFF};

  initial begin
    int pulses;
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
    reset = 1'b0; data = '0; dp_in = '0; wr_en = 1'b0; blank_lz = 1'b0;
`ifdef SEG_BRIGHTNESS_EN
    bright = 4'd15;
`endif

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_ack", {7'h0, upd_ack}, 8'h00);
    reset = 1'b1;
    cyc = 0;

    // Basic scan of all-zero data with guard cycles
    for (int d = 0; d < 4; d++) begin
      run_to(4*d + 1);
      chk("scan_guard_an", {4'h0, an}, 8'h0F);
      chk("scan_guard_seg", seg, 8'hC0);
      run_to(4*d + 2);
      chk("scan_an", {4'h0, an}, an_of(d));
      chk("scan_seg", seg, 8'hC0);
    end

    // Mid-frame write becomes visible only after the frame boundary
    run_to(18);
    write(16'h12AF, 4'b0100);
    run_to(31);
    chk("s2_hold_an", {4'h0, an}, 8'h07);
    chk("s2_hold_seg", seg, 8'hC0);
    chk("s2_hold_ack", {7'h0, upd_ack}, 8'h00);
    run_to(32);
    chk("s2_ack", {7'h0, upd_ack}, 8'h01);
    chk("s2_old_seg", seg, 8'hC0);
    run_to(33);
    chk("s2_ack_end", {7'h0, upd_ack}, 8'h00);
    chk("s2_guard_an", {4'h0, an}, 8'h0F);
    chk("s2_guard_seg", seg, 8'h8E);
    for (int d = 0; d < 4; d++) begin
      run_to(32 + 4*d + 2);
      chk("s2_an", {4'h0, an}, an_of(d));
      chk("s2_seg", seg, exp_s2[d]);
    end

    // Leading-zero blanking
    write(16'h0050, 4'b0000);
    blank_lz = 1'b1;
    run_to(48);
    chk("s3_ack", {7'h0, upd_ack}, 8'h01);
    for (int d = 0; d < 4; d++) begin
      run_to(48 + 4*d + 2);
      chk("s3_an", {4'h0, an}, an_of(d));
      chk("s3_seg", seg, exp_s3[d]);
    end
    write(16'h0000, 4'b0100);
    run_to(64);
    chk("s3z_ack", {7'h0, upd_ack}, 8'h01);
    for (int d = 0; d < 4; d++) begin
      run_to(64 + 4*d + 2);
      chk("s3z_an", {4'h0, an}, an_of(d));
      chk("s3z_seg", seg, exp_z[d]);
    end
    // blank_lz acts live on the currently displayed data
    blank_lz = 1'b0;
    run_to(79);
    chk("s3_live_seg", seg, 8'hC0);

    // Latest pending write wins; write on the boundary waits one frame
    run_to(81);
    write(16'h1111, 4'b0000);
    run_to(85);
    write(16'h2222, 4'b0000);
    run_to(95);
    chk("s4_pre_ack", {7'h0, upd_ack}, 8'h00);
    write(16'h3333, 4'b0000);
    chk("s4_ack1", {7'h0, upd_ack}, 8'h01);
    run_to(97);
    chk("s4_ack1_end", {7'h0, upd_ack}, 8'h00);
    chk("s4_guard_seg", seg, 8'hA4);
    run_to(98);
    chk("s4_an0", {4'h0, an}, 8'h0E);
    chk("s4_seg0", seg, 8'hA4);
    run_count(110, pulses);
    chk("s4_pulses", 8'(pulses), 8'd0);
    chk("s4_an3", {4'h0, an}, 8'h07);
    chk("s4_seg3", seg, 8'hA4);
    run_to(112);
    chk("s4_ack2", {7'h0, upd_ack}, 8'h01);
    run_to(114);
    chk("s4_new_an", {4'h0, an}, 8'h0E);
    chk("s4_new_seg", seg, 8'hB0);

    // Reset mid-frame discards the pending write
    write(16'hBEEF, 4'b0000);
    run_to(120);
    reset = 1'b0;
    repeat (3) tick();
    chk("s5_rst_an", {4'h0, an}, 8'h0F);
    chk("s5_rst_seg", seg, 8'hFF);
    chk("s5_rst_ack", {7'h0, upd_ack}, 8'h00);
    reset = 1'b1;
    cyc = 0;
    run_count(2, pulses);
    chk("s5_an0", {4'h0, an}, 8'h0E);
    chk("s5_seg0", seg, 8'hC0);
    run_to(18);
    chk("s5_seg_after_bnd", seg, 8'hC0);
    run_count(40, pulses);
    chk("s5_no_ack", 8'(pulses), 8'd0);

`ifdef SEG_BRIGHTNESS_EN
    // Dimmed: anode low only when the pwm count is within the setting
    begin
      int lows;
      lows = 0;
      bright = 4'd3;
      for (int k = 41; k <= 72; k++) begin
        logic [7:0] e;
        tick();
        if ((k % 4 == 1) || (((k - 1) % 16) > 3)) e = 8'h0F;
        else e = an_of(((k - 1) / 4) % 4);
        chk("pwm3_an", {4'h0, an}, e);
        if (an != 4'hF) lows++;
      end
      chk("pwm3_lows", 8'(lows), 8'd6);
      bright = 4'd15;
      for (int k = 73; k <= 88; k++) begin
        logic [7:0] e;
        tick();
        e = (k % 4 == 1) ? 8'h0F : an_of(((k - 1) / 4) % 4);
        chk("pwm15_an", {4'h0, an}, e);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
